// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates one byte-wide synchronous RAM between instruction fetch and load/store.
// Optional feature macro MEMCTRL_LAST_WORD_EN adds a one-entry last-fetched-word buffer.
module mem_ctrl #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_read,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_ready,
  output logic [31:0]       if_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  output logic              busy,
  output logic [2:0]        waiting_time,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);
  typedef enum logic [1:0] {IDLE = 2'd0, IF_RD = 2'd1, MEM_RD = 2'd2, MEM_WR = 2'd3} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;        // edges elapsed since acceptance
  logic [2:0]        nbytes_q, nbytes_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wbuf_q, wbuf_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic [2:0]        wait_q, wait_d;
  logic              if_ready_q, if_ready_d;
  logic              mem_ready_q, mem_ready_d;
  logic              ram_wr_q, ram_wr_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic [2:0]        mem_n;
  logic              lw_hit;
  logic [31:0]       lw_data;

  assign mem_n = (mem_len == 2'd0) ? 3'd1 : (mem_len == 2'd1) ? 3'd2 : 3'd4;

`ifdef MEMCTRL_LAST_WORD_EN
  logic              lw_valid_q, lw_valid_d;
  logic [ADDR_W-1:0] lw_addr_q, lw_addr_d;
  logic [31:0]       lw_data_q, lw_data_d;
  logic              if_done;

  assign if_done = (state_q == IF_RD) && !if_flush && (cnt_q == nbytes_q);
  assign lw_hit  = lw_valid_q && if_read && !if_flush && !mem_read && !mem_write &&
                   (if_addr == lw_addr_q);
  assign lw_data = lw_data_q;

  always_comb begin
    lw_valid_d = lw_valid_q;
    lw_addr_d  = lw_addr_q;
    lw_data_d  = lw_data_q;
    if (state_q == IDLE && mem_write) begin
      lw_valid_d = 1'b0;
    end else if (if_done) begin
      lw_valid_d = 1'b1;
      lw_addr_d  = base_q;
      lw_data_d  = rbuf_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lw_valid_q <= 1'b0;
      lw_addr_q  <= '0;
      lw_data_q  <= '0;
    end else begin
      lw_valid_q <= lw_valid_d;
      lw_addr_q  <= lw_addr_d;
      lw_data_q  <= lw_data_d;
    end
  end
`else
  assign lw_hit  = 1'b0;
  assign lw_data = 32'd0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 3'd1;
    nbytes_d    = nbytes_q;
    base_d      = base_q;
    wbuf_d      = wbuf_q;
    rbuf_d      = rbuf_q;
    wait_d      = (wait_q == 3'd0) ? 3'd0 : wait_q - 3'd1;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    ram_wr_d    = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    case (state_q)
      IDLE: begin
        cnt_d  = 3'd0;
        wait_d = 3'd0;
        if (mem_write) begin
          state_d    = MEM_WR;
          nbytes_d   = mem_n;
          base_d     = mem_addr;
          ram_a_d    = mem_addr;
          ram_wr_d   = 1'b1;
          ram_dout_d = mem_wdata[7:0];
          wbuf_d     = {8'd0, mem_wdata[31:8]};
          wait_d     = mem_n;
        end else if (mem_read) begin
          state_d  = MEM_RD;
          nbytes_d = mem_n;
          base_d   = mem_addr;
          ram_a_d  = mem_addr;
          rbuf_d   = '0;
          wait_d   = mem_n + 3'd1;
        end else if (lw_hit) begin
          if_ready_d = 1'b1;
          if_data_d  = lw_data;
        end else if (if_read && !if_flush) begin
          state_d  = IF_RD;
          nbytes_d = 3'd4;
          base_d   = if_addr;
          ram_a_d  = if_addr;
          rbuf_d   = '0;
          wait_d   = 3'd5;
        end
      end
      IF_RD, MEM_RD: begin
        if (state_q == IF_RD && if_flush) begin
          state_d = IDLE;
          wait_d  = 3'd0;
        end else begin
          // ram_din lags its address by one cycle, so byte b lands two edges after it was addressed
          for (int b = 0; b < 4; b++) begin
            if (cnt_q == 3'(b + 1)) rbuf_d[8*b +: 8] = ram_din;
          end
          if (cnt_d < nbytes_q) ram_a_d = base_q + ADDR_W'(cnt_d);
          if (cnt_q == nbytes_q) begin
            state_d = IDLE;
            if (state_q == IF_RD) begin
              if_ready_d = 1'b1;
              if_data_d  = rbuf_d;
            end else begin
              mem_ready_d = 1'b1;
              mem_rdata_d = rbuf_d;
            end
          end
        end
      end
      MEM_WR: begin
        if (cnt_d < nbytes_q) begin
          ram_a_d    = base_q + ADDR_W'(cnt_d);
          ram_wr_d   = 1'b1;
          ram_dout_d = wbuf_q[7:0];
          wbuf_d     = {8'd0, wbuf_q[31:8]};
        end
        if (cnt_d == nbytes_q) begin
          state_d     = IDLE;
          mem_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      nbytes_q    <= '0;
      base_q      <= '0;
      wbuf_q      <= '0;
      rbuf_q      <= '0;
      wait_q      <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      ram_wr_q    <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nbytes_q    <= nbytes_d;
      base_q      <= base_d;
      wbuf_q      <= wbuf_d;
      rbuf_q      <= rbuf_d;
      wait_q      <= wait_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
      ram_wr_q    <= ram_wr_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign waiting_time = wait_q;
  assign if_ready     = if_ready_q;
  assign if_data      = if_data_q;
  assign mem_ready    = mem_ready_q;
  assign mem_rdata    = mem_rdata_q;
  assign ram_a        = ram_a_q;
  assign ram_wr       = ram_wr_q;
  assign ram_dout     = ram_dout_q;
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Arbitrates the single byte-wide synchronous main RAM between the instruction-fetch stage (32-bit instruction reads) and the memory stage (byte/half/word loads and stores).
- Serialises each request into consecutive byte cycles and assembles or disassembles little-endian data.
- Drives the busy and waiting-time indications that the fetch stage uses to pipeline its next request.

Parameters:
- ADDR_W, 17, RAM byte-address width; addresses wrap modulo 2^ADDR_W.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- if_read  in  1  fetch request (level); held with if_addr stable until if_ready or if_flush
- if_addr  in  ADDR_W  fetch byte address
- if_flush  in  1  branch redirect; aborts any pending or in-flight fetch
- if_ready  out  1  one-cycle pulse; if_data valid
- if_data  out  32  fetched instruction, little-endian
- mem_read  in  1  load request (level); held until mem_ready
- mem_write  in  1  store request (level); held until mem_ready
- mem_len  in  2  0 = byte, 1 = half, 2 or 3 = word
- mem_addr  in  ADDR_W  load/store byte address
- mem_wdata  in  32  store data; low bytes used first
- mem_ready  out  1  one-cycle pulse; load data valid or store complete
- mem_rdata  out  32  load data, zero-extended
- busy  out  1  high whenever state is not IDLE
- waiting_time  out  3  edges remaining until the current transfer's ready edge; saturates at 7; 0 in IDLE
- ram_a  out  ADDR_W  RAM byte address
- ram_wr  out  1  1 = write ram_dout this cycle
- ram_dout  out  8  RAM write data
- ram_din  in  8  RAM read data; valid the cycle after its address

Behaviour:
- Reset: asynchronous, active low. State goes to IDLE; if_ready, mem_ready, busy, ram_wr, waiting_time go to 0; if_data, mem_rdata, ram_a, ram_dout go to 0. Reset asserted mid-transfer abandons the transfer with no ready pulse.
- States: IDLE, IF_RD, MEM_RD, MEM_WR.
- IDLE arbitration at each edge:
  - mem_write or mem_read asserted goes to MEM_WR or MEM_RD respectively.
  - Otherwise if_read && !if_flush goes to IF_RD.
  - MEM has fixed priority over IF.
  - mem_read and mem_write both high is illegal; write wins.
- Acceptance edge = edge 0. Byte i (i = 0 .. n-1) is addressed at ram_a = addr + i during the cycle following edge i.
- Reads:
  - Byte i is captured from ram_din at edge i+2 into bits [8i+7:8i].
  - The ready pulse is set at edge n+1 together with the last capture.
  - Latency: word 5 edges, half 3, byte 2.
  - Upper bytes of mem_rdata are zero.
- Writes:
  - ram_wr = 1 and ram_dout = mem_wdata byte i during the cycle following edge i.
  - mem_ready is set at edge n (word: 4 edges).
- The ready pulse lasts exactly one cycle. The state returns to IDLE on the same edge that sets ready. A new request is accepted at the next edge, so there is no acceptance during the ready cycle.
- waiting_time at edge k of an n-edge transfer = n - k. The fetch stage may issue its next request when waiting_time <= 1.
- ram_wr = 0 in every cycle except write byte cycles. ram_a holds its last value in IDLE.
- if_flush:
  - In IF_RD, the state returns to IDLE at the next edge, with no if_ready and if_data unchanged.
  - In IDLE, it suppresses IF acceptance.
  - It does not affect MEM transfers.
- The requester must hold its request until ready. If a request drops early, the transfer still completes and the ready pulse is still issued.

Optional Feature:
MEMCTRL_LAST_WORD_EN
- Defined:
  - A one-entry buffer (valid, addr, data) is loaded on every completed IF_RD.
  - In IDLE, with no MEM request, an if_read with if_addr equal to the buffer address and valid = 1 raises if_ready with the buffered data at the next edge. No RAM cycles are issued and the state stays IDLE.
  - Any accepted mem_write clears valid. Reset clears valid.
- Undefined: no buffer; every fetch goes to RAM.

Test Plan:
- RAM holds 0x13,0x05,0x10,0x00 at 0x0100; if_read, if_addr = 0x0100 -> if_ready at edge 5, if_data = 0x00100513, busy high for edges 0-4, waiting_time 5,4,3,2,1 then 0.
- mem_write, mem_len = 2, mem_addr = 0x0200, mem_wdata = 0xDEADBEEF -> ram_wr on 4 cycles with ram_dout EF,BE,AD,DE at 0x200..0x203; mem_ready at edge 4. A following mem_read, mem_len = 1, addr 0x0202 -> mem_rdata = 0x0000DEAD at edge 3.
- if_read and mem_read asserted in the same IDLE cycle -> MEM served first. IF is accepted the edge after mem_ready and delivered 5 edges later.
- if_flush at edge 2 of an IF_RD -> no if_ready; state IDLE at edge 3. A new if_read at address 0x0300 completes normally.
- reset_n pulsed low during edge 2 of a word write -> all outputs 0 immediately, no mem_ready, IDLE after release.
- With MEMCTRL_LAST_WORD_EN: repeat fetch of 0x0100 -> if_ready 1 edge after request with no ram_a activity. A mem_write to any address, then fetch 0x0100 -> full 5-edge RAM fetch.
